// File: rtl/tlrb_aib_link_seq_if.sv
// Purpose : reset/POR control and status bundle between the link sequencer and one TLRB AIB PHY channel.
// Latency : none, plain wires; the status lines are asynchronous to the sequencer clock.
// Backpressure: none, level signalling only. master = sequencer (drives control, reads status), slave = PHY wrapper.
interface tlrb_aib_link_seq_if;
    // control towards the PHY
    logic por_in;
    logic adap_irstb;
    logic rstn_in;
    logic adap_rstn_in;
    // status from the PHY (asynchronous)
    logic por_out;
    logic device_detect;
    logic rstn_out;
    logic adap_rstn_out;

    modport master (
        output por_in, adap_irstb, rstn_in, adap_rstn_in,
        input  por_out, device_detect, rstn_out, adap_rstn_out
    );

    modport slave (
        input  por_in, adap_irstb, rstn_in, adap_rstn_in,
        output por_out, device_detect, rstn_out, adap_rstn_out
    );
endinterface

// File: rtl/tlrb_aib_link_seq.sv
// Purpose : brings one TLRB AIB PHY channel from power-on to link-up (master or slave role), then supervises it.
// Latency : PHY status passes a 2-flop synchronizer; every output is a flop, so decisions land 3 edges after a status change.
// Backpressure: none; enable=0 returns to IDLE from any state. Optional auto-retry: `define TLRB_AIB_LINK_SEQ_RETRY_EN.
// Ports: clk/rst (sync, active high), enable, ms_nsl (1 = master), phy (interface, master modport),
//        link_up, fault (sticky), state (3b encoding), retry_cnt (0 unless auto-retry is built in).
module tlrb_aib_link_seq #(
    parameter int CNTW    = 16,
    parameter int DET_TO  = 1000,
    parameter int POR_CYC = 64,
    parameter int RST_GAP = 16,
    parameter int RSP_TO  = 1000
`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
    ,
    parameter int RETRY_CYC = 256
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       ms_nsl,
    tlrb_aib_link_seq_if.master        phy,
    output logic                       link_up,
    output logic                       fault,
    output logic [2:0]                 state,
    output logic [3:0]                 retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DETECT   = 3'd1,
        S_POR_HOLD = 3'd2,
        S_PHY_RST  = 3'd3,
        S_ADAP_RST = 3'd4,
        S_LINK_UP  = 3'd5,
        S_FAULT    = 3'd6
    } state_t;

    // Counter values on the last cycle of each wait window.
    localparam logic [CNTW-1:0] DET_LIM = CNTW'(DET_TO - 1);
    localparam logic [CNTW-1:0] POR_LIM = CNTW'(POR_CYC - 1);
    localparam logic [CNTW-1:0] GAP_LIM = CNTW'(RST_GAP - 1);
    localparam logic [CNTW-1:0] RSP_LIM = CNTW'(RSP_TO - 1);
`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
    localparam logic [CNTW-1:0] RTY_LIM = CNTW'(RETRY_CYC - 1);
`endif

    // Synchronizers, bit order {por_out, device_detect, rstn_out, adap_rstn_out}.
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       por_s;
    logic       det_s;
    logic       rstn_s;
    logic       adap_s;

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt_q;
    logic            cnt_clr;
    // PHY_RST has two phases: 0 = gap before releasing rstn_in, 1 = waiting for the remote rstn_out.
    logic            phase_q;
    logic            phase_d;

    logic por_q,   por_d;
    logic irstb_q, irstb_d;
    logic rstn_q,  rstn_d;
    logic adap_q,  adap_d;
    logic link_q,  link_d;
    logic fault_q, fault_d;
    logic [3:0] retry_q, retry_d;

    logic det_ok;
    logic link_lost;

    assign {por_s, det_s, rstn_s, adap_s} = sync2;

    // Master waits for the far side to leave POR; slave waits to see the far device.
    assign det_ok    = ms_nsl ? ~por_s : det_s;
    assign link_lost = ~rstn_s | ~adap_s | (ms_nsl ? por_s : ~det_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {phy.por_out, phy.device_detect, phy.rstn_out, phy.adap_rstn_out};
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_clr = 1'b0;
        por_d   = por_q;
        irstb_d = irstb_q;
        rstn_d  = rstn_q;
        adap_d  = adap_q;
        link_d  = link_q;
        fault_d = fault_q;
        retry_d = retry_q;

        case (state_q)
            S_IDLE: begin
                por_d = ~ms_nsl;
                if (enable) state_d = S_DETECT;
            end
            S_DETECT: begin
                // A condition seen on the timeout cycle still wins.
                if (det_ok)                state_d = ms_nsl ? S_PHY_RST : S_POR_HOLD;
                else if (cnt_q == DET_LIM) state_d = S_FAULT;
            end
            S_POR_HOLD: begin
                if (cnt_q == POR_LIM) state_d = S_PHY_RST;
            end
            S_PHY_RST: begin
                if (!phase_q) begin
                    if (cnt_q == GAP_LIM) begin
                        phase_d = 1'b1;
                        cnt_clr = 1'b1;
                        rstn_d  = 1'b1;
                    end
                end else if (rstn_s) begin
                    state_d = S_ADAP_RST;
                end else if (cnt_q == RSP_LIM) begin
                    state_d = S_FAULT;
                end
            end
            S_ADAP_RST: begin
                if (adap_s)                state_d = S_LINK_UP;
                else if (cnt_q == RSP_LIM) state_d = S_FAULT;
            end
            S_LINK_UP: begin
                if (link_lost) state_d = S_FAULT;
            end
            S_FAULT: begin
                // Entry leaves the control lines alone for one cycle; from then on they are held in reset.
                por_d   = ~ms_nsl;
                irstb_d = 1'b0;
                rstn_d  = 1'b0;
                adap_d  = 1'b0;
`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
                if (cnt_q == RTY_LIM && retry_q != 4'hF) begin
                    state_d = S_DETECT;
                    retry_d = retry_q + 4'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable && state_q != S_IDLE) state_d = S_IDLE;

        // Entry actions; these override anything the per-state branch set above.
        if (state_d != state_q) begin
            cnt_clr = 1'b1;
            phase_d = 1'b0;
            case (state_d)
                S_IDLE: begin
                    por_d   = ~ms_nsl;
                    irstb_d = 1'b0;
                    rstn_d  = 1'b0;
                    adap_d  = 1'b0;
                    link_d  = 1'b0;
                    fault_d = 1'b0;
                    retry_d = 4'd0;
                end
                S_DETECT: begin
                    link_d  = 1'b0;
                    fault_d = 1'b0;
                end
                S_POR_HOLD: por_d = 1'b1;
                S_PHY_RST: begin
                    por_d   = 1'b0;
                    irstb_d = 1'b1;
                    rstn_d  = 1'b0;
                end
                S_ADAP_RST: adap_d = 1'b1;
                S_LINK_UP:  link_d = 1'b1;
                S_FAULT: begin
                    link_d  = 1'b0;
                    fault_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            por_q   <= ~ms_nsl;
            irstb_q <= 1'b0;
            rstn_q  <= 1'b0;
            adap_q  <= 1'b0;
            link_q  <= 1'b0;
            fault_q <= 1'b0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_clr ? '0 : cnt_q + CNTW'(1);
            por_q   <= por_d;
            irstb_q <= irstb_d;
            rstn_q  <= rstn_d;
            adap_q  <= adap_d;
            link_q  <= link_d;
            fault_q <= fault_d;
            retry_q <= retry_d;
        end
    end

    assign phy.por_in       = por_q;
    assign phy.adap_irstb   = irstb_q;
    assign phy.rstn_in      = rstn_q;
    assign phy.adap_rstn_in = adap_q;
    assign link_up          = link_q;
    assign fault            = fault_q;
    assign state            = state_q;
    assign retry_cnt        = retry_q;

endmodule

// File: tb/tb_tlrb_aib_link_seq.sv
// Bench for tlrb_aib_link_seq: directed PHY stimulus, a timeline model of the sequencer checked every cycle,
// plus hand-computed expectations for the key latencies. One DUT with DET_TO=20, POR_CYC=8, RST_GAP=4,
// RSP_TO=50 (and RETRY_CYC=10 when auto-retry is built in).
module tb_tlrb_aib_link_seq;
    localparam int DET_TO    = 20;
    localparam int POR_CYC   = 8;
    localparam int RST_GAP   = 4;
    localparam int RSP_TO    = 50;
    localparam int RETRY_CYC = 10;

    typedef struct packed {
        logic       por;
        logic       irstb;
        logic       rstn_i;
        logic       adap_i;
        logic       link;
        logic       flt;
        logic [2:0] st;
        logic [3:0] rc;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       ms_nsl;
    logic       link_up;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    tlrb_aib_link_seq_if phy_if ();

    tlrb_aib_link_seq #(
        .CNTW    (16),
        .DET_TO  (DET_TO),
        .POR_CYC (POR_CYC),
        .RST_GAP (RST_GAP),
        .RSP_TO  (RSP_TO)
`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
        ,
        .RETRY_CYC (RETRY_CYC)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ms_nsl    (ms_nsl),
        .phy       (phy_if.master),
        .link_up   (link_up),
        .fault     (fault),
        .state     (state),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    obs_t dut_o;
    assign dut_o = {phy_if.por_in, phy_if.adap_irstb, phy_if.rstn_in, phy_if.adap_rstn_in,
                    link_up, fault, state, retry_cnt};

    // ---------------- model: state plus age-in-state timeline ----------------
    obs_t       exp_o;
    bit         model_ok = 1'b0;
    int         m_st  = 0;
    int         m_age = 0;
    int         m_rc  = 0;
    int         nxt;
    logic [3:0] h1, h2, seen;   // {por_out, device_detect, rstn_out, adap_rstn_out} as the DUT sees them

    function automatic obs_t outs(input int s, input int age, input int rc, input logic ms);
        obs_t o;
        o    = '0;
        o.st = 3'(s);
        o.rc = 4'(rc);
        case (s)
            0, 1: o.por = ~ms;
            2:    o.por = 1'b1;
            3: begin
                o.irstb  = 1'b1;
                o.rstn_i = (age >= RST_GAP);
            end
            4: {o.irstb, o.rstn_i, o.adap_i} = 3'b111;
            5: {o.irstb, o.rstn_i, o.adap_i, o.link} = 4'b1111;
            6: begin
                o.por = ~ms;
                o.flt = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    always @(posedge clk) begin
        seen = h2;
        h2   = h1;
        h1   = {phy_if.por_out, phy_if.device_detect, phy_if.rstn_out, phy_if.adap_rstn_out};
        if (rst) begin
            h1 = '0;
            h2 = '0;
            m_st = 0;
            m_age = 0;
            m_rc = 0;
            exp_o = outs(0, 0, 0, ms_nsl);
            model_ok = 1'b1;
        end else if (model_ok) begin
            nxt = m_st;
            if (!enable) nxt = 0;
            else begin
                case (m_st)
                    0: nxt = 1;
                    1: begin
                        if (ms_nsl ? !seen[3] : seen[2]) nxt = ms_nsl ? 3 : 2;
                        else if (m_age == DET_TO - 1) nxt = 6;
                    end
                    2: if (m_age == POR_CYC - 1) nxt = 3;
                    3: begin
                        if (m_age >= RST_GAP) begin
                            if (seen[1]) nxt = 4;
                            else if (m_age - RST_GAP == RSP_TO - 1) nxt = 6;
                        end
                    end
                    4: begin
                        if (seen[0]) nxt = 5;
                        else if (m_age == RSP_TO - 1) nxt = 6;
                    end
                    5: if (!seen[1] || !seen[0] || (ms_nsl ? seen[3] : !seen[2])) nxt = 6;
                    6: begin
`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
                        if (m_age == RETRY_CYC - 1 && m_rc < 15) begin
                            nxt  = 1;
                            m_rc = m_rc + 1;
                        end
`endif
                    end
                    default: nxt = 0;
                endcase
            end
            if (nxt == 0) m_rc = 0;
            if (nxt != m_st) m_age = 0;
            else             m_age = m_age + 1;
            if (nxt == 6 && m_st != 6) begin
                // first FAULT cycle keeps the previous control levels
                exp_o.link = 1'b0;
                exp_o.flt  = 1'b1;
                exp_o.st   = 3'd6;
            end else begin
                exp_o = outs(nxt, m_age, m_rc, ms_nsl);
            end
            m_st = nxt;
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, dut_o, exp_o);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [2:0] trace[$];
    bit         trace_on = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (trace_on && (trace.size() == 0 || trace[$] != state)) trace.push_back(state);
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int n;
        n = 0;
        while (state != s && n < lim) begin
            step();
            n++;
        end
        check(nm, int'(state), int'(s));
    endtask

    // sel 0 = rstn_in, 1 = adap_rstn_in
    task automatic wait_ctrl(input int sel, input int lim, input string nm);
        int n;
        n = 0;
        while ((sel == 0 ? phy_if.rstn_in : phy_if.adap_rstn_in) !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        check(nm, int'(sel == 0 ? phy_if.rstn_in : phy_if.adap_rstn_in), 1);
    endtask

    initial begin
        int t0, t1, n2, n2p, n;
        logic [11:0] tv;

        rst = 1'b1;
        enable = 1'b0;
        ms_nsl = 1'b1;
        phy_if.por_out = 1'b0;
        phy_if.device_detect = 1'b0;
        phy_if.rstn_out = 1'b0;
        phy_if.adap_rstn_out = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_outputs", int'(dut_o), 0);

        // ---- master happy path ----
        trace_on = 1'b1;
        enable = 1'b1;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 100 && t1 < 0; i++) begin
            step();
            if (t0 < 0 && phy_if.adap_irstb) t0 = cyc;
            if (t1 < 0 && phy_if.rstn_in) t1 = cyc;
        end
        check("rstn_in_seen", int'(t1 >= 0), 1);
        check("irstb_to_rstn_gap", t1 - t0, RST_GAP);
        repeat (10) step();
        phy_if.rstn_out = 1'b1;
        wait_ctrl(1, 40, "adap_rstn_in_seen");
        repeat (5) step();
        phy_if.adap_rstn_out = 1'b1;
        wait_state(3'd5, 40, "master_link_up_state");
        trace_on = 1'b0;
        check("master_link_up", int'(link_up), 1);
        check("master_por_in", int'(phy_if.por_in), 0);
        tv = '0;
        foreach (trace[i]) if (i < 4) tv = {tv[8:0], trace[i]};
        check("master_trace_len", trace.size(), 4);
        check("master_trace", int'(tv), int'({3'd1, 3'd3, 3'd4, 3'd5}));

        // ---- link loss: adap_rstn_out low for 3 cycles ----
        phy_if.adap_rstn_out = 1'b0;
        step();
        step();
        check("loss_still_up", int'(state), 5);
        step();
        phy_if.adap_rstn_out = 1'b1;
        check("loss_fault_state", int'(state), 6);
        check("loss_flags", int'({link_up, fault}), 1);
        check("loss_entry_irstb_held", int'(phy_if.adap_irstb), 1);
        step();
        check("loss_resets_reasserted",
              int'({phy_if.adap_irstb, phy_if.rstn_in, phy_if.adap_rstn_in}), 0);
        enable = 1'b0;
        phy_if.rstn_out = 1'b0;
        phy_if.adap_rstn_out = 1'b0;
        step();
        check("loss_idle", int'({state, fault}), 0);
        repeat (3) step();

        // ---- detect timeout (master, far side stuck in POR) ----
        phy_if.por_out = 1'b1;
        repeat (3) step();
        enable = 1'b1;
        wait_state(3'd1, 5, "det_enter");
        t0 = cyc;
        wait_state(3'd6, 60, "det_timeout_fault");
        check("det_timeout_cycles", cyc - t0, DET_TO);
        check("det_fault_flag", int'(fault), 1);
        step();
        check("det_resets", int'({phy_if.adap_irstb, phy_if.rstn_in, phy_if.adap_rstn_in, phy_if.por_in}), 0);
        enable = 1'b0;
        step();
        check("det_idle", int'({state, fault}), 0);
        phy_if.por_out = 1'b0;
        repeat (3) step();

        // ---- boundary: rstn_out seen exactly on the last response cycle ----
        enable = 1'b1;
        wait_ctrl(0, 60, "bnd_rstn_in_seen");
        repeat (RSP_TO - 3) step();
        phy_if.rstn_out = 1'b1;
        n = 0;
        while (state == 3'd3 && n < 10) begin
            step();
            n++;
        end
        check("bnd_adap_rst_not_fault", int'(state), 4);
        rst = 1'b1;
        step();
        check("bnd_rst_outputs", int'(dut_o), 0);
        rst = 1'b0;
        enable = 1'b0;
        phy_if.rstn_out = 1'b0;
        repeat (3) step();

        // ---- ADAP_RST response timeout ----
        enable = 1'b1;
        wait_ctrl(0, 60, "adto_rstn_in_seen");
        phy_if.rstn_out = 1'b1;
        wait_state(3'd4, 10, "adto_enter");
        t0 = cyc;
        wait_state(3'd6, 80, "adto_fault");
        check("adto_cycles", cyc - t0, RSP_TO);
        enable = 1'b0;
        phy_if.rstn_out = 1'b0;
        repeat (3) step();

        // ---- slave path ----
        ms_nsl = 1'b0;
        phy_if.device_detect = 1'b1;
        repeat (3) step();
        check("slave_idle_por", int'(phy_if.por_in), 1);
        enable = 1'b1;
        n2 = 0;
        n2p = 0;
        n = 0;
        while (state != 3'd3 && n < 100) begin
            step();
            n++;
            if (state == 3'd2) begin
                n2++;
                if (phy_if.por_in) n2p++;
            end
        end
        check("slave_phy_rst", int'(state), 3);
        check("slave_por_hold_cycles", n2, POR_CYC);
        check("slave_por_high_cycles", n2p, POR_CYC);
        check("slave_por_released", int'(phy_if.por_in), 0);
        wait_ctrl(0, 20, "slave_rstn_in_seen");
        repeat (3) step();
        phy_if.rstn_out = 1'b1;
        wait_ctrl(1, 20, "slave_adap_rstn_in_seen");
        repeat (2) step();
        phy_if.adap_rstn_out = 1'b1;
        wait_state(3'd5, 20, "slave_link_up_state");
        check("slave_link", int'({link_up, phy_if.por_in}), 2);
        enable = 1'b0;
        step();
        phy_if.device_detect = 1'b0;
        phy_if.rstn_out = 1'b0;
        phy_if.adap_rstn_out = 1'b0;
        ms_nsl = 1'b1;
        repeat (3) step();

`ifdef TLRB_AIB_LINK_SEQ_RETRY_EN
        // ---- auto-retry saturation ----
        phy_if.por_out = 1'b1;
        repeat (3) step();
        enable = 1'b1;
        n = 0;
        while (!(retry_cnt == 4'd15 && state == 3'd6) && n < 3000) begin
            step();
            n++;
        end
        check("retry_saturated", int'(retry_cnt), 15);
        repeat (200) step();
        check("retry_terminal", int'({state, retry_cnt}), int'({3'd6, 4'd15}));
        enable = 1'b0;
        step();
        check("retry_cleared", int'({state, retry_cnt}), 0);
        phy_if.por_out = 1'b0;
        repeat (3) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
